tick_generator: RTL and testbench
=================================

// Module: tick_generator
// PURPOSE
//  Multi-channel, parametrised enable-tick generator; successor to the fixed 1 Hz divider.
//  Each channel runs a down-counter with a divisor programmable at run time.
//  Each channel emits a one-cycle tick; optionally it also emits a 50%-style toggle output.
//  Sits between the board clock and the traffic-light FSMs: timers, blink, pedestrian beeper.
// PARAMETERS
//  CLK_HZ   5_000_000   input clock frequency; documentation and default-divisor arithmetic only
//  NUM_CH   2           number of independent tick channels, 1..16
//  CH_W     1           width of cfg_ch; must satisfy 2**CH_W >= NUM_CH
//  CNT_W    24          counter/divisor width
//  DEF_DIV  CLK_HZ      reset divisor for every channel (1 Hz tick); must be >=2 and < 2**CNT_W
// PORTS
//  clock    in   1          rising-edge clock
//  reset    in   1          synchronous, active-high reset
//  enable   in   1          global run; when low, all counters hold
//  sync_clr in   1          restart all channels phase-aligned
//  cfg_we   in   1          divisor write strobe, single cycle
//  cfg_ch   in   CH_W       channel index for the write
//  cfg_div  in   CNT_W      new divisor, in clock cycles per tick
//  cfg_ack  out  1          one-cycle pulse: write accepted
//  cfg_err  out  1          one-cycle pulse: write rejected
//  tick     out  NUM_CH     per-channel one-cycle enable pulse, registered
//  sq       out  NUM_CH     per-channel toggle output, registered
// BEHAVIOUR
//  Reset (sync, reset=1 at edge): for every channel div=DEF_DIV, cnt=DEF_DIV-1.
//   All outputs reset to 0: tick, sq, cfg_ack, cfg_err. Reset overrides every other input.
//  Per-channel counting, per edge, in priority order:
//   1. sync_clr=1: cnt<=div-1, tick<=0, sq<=0.
//   2. enable=1 and cnt==0: cnt<=div-1, tick<=1, sq<=~sq.
//   3. enable=1 and cnt!=0: cnt<=cnt-1, tick<=0.
//   4. enable=0: cnt and sq hold, tick<=0.
//  Timing: with enable held high from release, first tick is high after the DEF_DIV-th edge.
//   Thereafter tick is high for exactly 1 cycle every div cycles. sq period = 2*div cycles.
//  Config write (cfg_we=1 at edge):
//   Valid when cfg_ch<NUM_CH and 2<=cfg_div. On valid: div[cfg_ch]<=cfg_div; cfg_ack=1 next cycle.
//   Invalid: div unchanged; cfg_err=1 next cycle.
//   No handshake stall: a write is accepted every cycle; back-to-back writes are legal.
//  Glitch-free update: a new div does not disturb the running count.
//   It is first used at that channel's next reload (case 1 or 2).
//  Simultaneous events:
//   - cfg_we + sync_clr: the reload uses the NEW divisor (cnt<=cfg_div-1).
//   - cfg_we on the reload edge of the target channel: the reload uses the NEW divisor.
//   - Any event when reset=1: ignored; cfg_ack/cfg_err stay 0.
//  Reset mid-count: counter restarts from DEF_DIV-1. Any programmed divisor is lost.
//  Arithmetic: unsigned CNT_W; cnt never wraps below 0 because reload occurs at 0.
// CONFIGURATION
//  TICK_GEN_SQUARE_EN defined: sq toggles as above.
//  Not defined: sq is tied to 0; no sq flops are instantiated; tick behaviour is identical.
// STRUCTURE
//  Package tick_gen_pkg holds:
//   - MIN_DIV = 2
//   - typedef logic [CNT_W-1:0] div_t (CNT_W is a package localparam, default 24)
//   - function div_valid(div_t d)
//  Sub-module tick_channel holds one channel: div and cnt registers, tick/sq flops, reload logic.
//   Inputs: en, clr, load, load_div.
//  The top generates NUM_CH instances and adds the cfg decode plus ack/err flops.
// TESTING (NUM_CH=2, DEF_DIV=5, CNT_W=8 unless noted)
//  1. Reset release, enable=1:
//     tick[0] and tick[1] high after edges 5, 10, 15; each pulse is 1 cycle wide.
//     With TICK_GEN_SQUARE_EN, sq rises at edge 5 and falls at edge 10.
//  2. Write ch1 div=3 at edge 2:
//     cfg_ack pulses at edge 2 output. ch1 ticks at edges 5, 8, 11. ch0 is unaffected at 5, 10.
//  3. Invalid writes: cfg_div=1 -> cfg_err pulse; cfg_ch=3 with CH_W=2 -> cfg_err pulse.
//     Divisors are unchanged and tick timing is unchanged.
//  4. enable low from edge 3 to 7, then high:
//     No ticks while low. Next tick occurs 2 counting edges after re-enable (phase held).
//  5. sync_clr at edge 7 together with a ch0 write of div=4:
//     sq<=0. ch0 ticks at edges 11, 15. ch1 ticks at edges 12, 17.
//  6. reset asserted mid-count at edge 6 with ch0 div=3 programmed:
//     All outputs are 0 one cycle later. After release, ticks return to period 5.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the tick generator slice.
package tick_gen_pkg;

    localparam int unsigned CNT_W   = 24;
    localparam int unsigned MIN_DIV = 2;

    typedef logic [CNT_W-1:0] div_t;

    function automatic logic div_valid(div_t d);
        return d >= div_t'(MIN_DIV);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divisor/count registers, tick flop and optional toggle flop.
// The toggle output exists only when TICK_GEN_SQUARE_EN is defined.
module tick_channel #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned DEF_DIV = 5_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload_div;
    logic             wrap;

    // A divisor written on a reload edge takes effect on that same reload.
    always_comb begin
        reload_div = load ? load_div : div_q;
        wrap       = en && (cnt == '0) && !clr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= CNT_W'(DEF_DIV);
            cnt   <= CNT_W'(DEF_DIV - 1);
            tick  <= 1'b0;
        end else begin
            if (load) begin
                div_q <= load_div;
            end
            if (clr) begin
                cnt  <= reload_div - 1'b1;
                tick <= 1'b0;
            end else if (en) begin
                if (cnt == '0) begin
                    cnt  <= reload_div - 1'b1;
                    tick <= 1'b1;
                end else begin
                    cnt  <= cnt - 1'b1;
                    tick <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            sq <= 1'b0;
        end else if (wrap) begin
            sq <= ~sq;
        end
    end
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable enable-tick generator with config write decode.
// Define TICK_GEN_SQUARE_EN to enable the per-channel toggle outputs.
module tick_generator #(
    parameter int unsigned CLK_HZ  = 5_000_000,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CH_W    = 1,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned DEF_DIV = CLK_HZ
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    import tick_gen_pkg::*;

    logic cfg_ok;

    always_comb begin
        cfg_ok = (32'(cfg_ch) < NUM_CH) && (cfg_div >= CNT_W'(MIN_DIV));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_we && cfg_ok;
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .en       (enable),
            .clr      (sync_clr),
            .load     (cfg_we && cfg_ok && (cfg_ch == CH_W'(i))),
            .load_div (cfg_div),
            .tick     (tick[i]),
            .sq       (sq[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator against a period/phase reference model.
module tb_tick_generator;

    localparam int NCH  = 2;
    localparam int CHW  = 2;
    localparam int CW   = 8;
    localparam int DDIV = 5;

    logic           clock = 1'b0;
    logic           reset, enable, sync_clr, cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_ack, cfg_err;
    logic [NCH-1:0] tick, sq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: elapsed enabled edges in the current period, period length,
    // and the divisor that the next period will use.
    int m_e[NCH], m_p[NCH], m_d[NCH];
    bit m_tick[NCH], m_sq[NCH];
    bit m_ack, m_err;

    always #5 clock = ~clock;

    tick_generator #(
        .CLK_HZ  (DDIV),
        .NUM_CH  (NCH),
        .CH_W    (CHW),
        .CNT_W   (CW),
        .DEF_DIV (DDIV)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .sync_clr (sync_clr),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_ack  (cfg_ack),
        .cfg_err  (cfg_err),
        .tick     (tick),
        .sq       (sq)
    );

    function automatic void model_edge();
        bit ok;
        int nd;
        if (reset) begin
            m_ack = 0; m_err = 0;
            for (int i = 0; i < NCH; i++) begin
                m_d[i] = DDIV; m_p[i] = DDIV; m_e[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
            end
        end else begin
            ok    = (int'(cfg_ch) < NCH) && (int'(cfg_div) >= 2);
            m_ack = cfg_we && ok;
            m_err = cfg_we && !ok;
            for (int i = 0; i < NCH; i++) begin
                nd = (cfg_we && ok && int'(cfg_ch) == i) ? int'(cfg_div) : m_d[i];
                m_tick[i] = 0;
                if (sync_clr) begin
                    m_p[i] = nd; m_e[i] = 0; m_sq[i] = 0;
                end else if (enable) begin
                    m_e[i]++;
                    if (m_e[i] == m_p[i]) begin
                        m_tick[i] = 1; m_sq[i] = !m_sq[i]; m_p[i] = nd; m_e[i] = 0;
                    end
                end
                m_d[i] = nd;
            end
        end
    endfunction

    function automatic logic [5:0] exp_vec();
        logic [1:0] t, s;
        for (int i = 0; i < NCH; i++) begin
            t[i] = m_tick[i];
`ifdef TICK_GEN_SQUARE_EN
            s[i] = m_sq[i];
`else
            s[i] = 1'b0;
`endif
        end
        return {m_ack, m_err, s, t};
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] want;
        do_reset();
        n_checks++;
        if ({cfg_ack, cfg_err, sq, tick} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000", {cfg_ack, cfg_err, sq, tick});
        end
        for (int n = 1; n <= 15; n++) begin
            step();
            want = (n % 5 == 0) ? 2'b11 : 2'b00;
            n_checks++;
            if (tick !== want) begin
                n_fail++;
                $display("FAIL reset_tick_sched edge %0d: got %b expected %b", n, tick, want);
            end
            n_checks++;
            if ({cfg_ack, cfg_err, sq, tick} !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_model edge %0d: got %b expected %b", n, {cfg_ack, cfg_err, sq, tick}, exp_vec());
            end
        end
    endtask

    task automatic test_config_write();
        logic [1:0] want;
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            cfg_we = (n == 2); cfg_ch = 2'd1; cfg_div = 8'd3;
            step();
            cfg_we = 1'b0;
            want[0] = (n % 5 == 0);
            want[1] = (n == 5 || n == 8 || n == 11);
            n_checks++;
            if (tick !== want || cfg_ack !== (n == 2) || cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_write edge %0d: got tick=%b ack=%b err=%b expected tick=%b ack=%b err=0",
                         n, tick, cfg_ack, cfg_err, want, (n == 2));
            end
            n_checks++;
            if ({cfg_ack, cfg_err, sq, tick} !== exp_vec()) begin
                n_fail++;
                $display("FAIL cfg_write_model edge %0d: got %b expected %b", n, {cfg_ack, cfg_err, sq, tick}, exp_vec());
            end
        end
    endtask

    task automatic test_invalid_write();
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            cfg_we  = (n == 2 || n == 4);
            cfg_ch  = (n == 4) ? 2'd3 : 2'd0;
            cfg_div = (n == 4) ? 8'd3 : 8'd1;
            step();
            cfg_we = 1'b0;
            n_checks++;
            if (cfg_err !== (n == 2 || n == 4) || cfg_ack !== 1'b0 ||
                tick !== ((n % 5 == 0) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL invalid_write edge %0d: got err=%b ack=%b tick=%b", n, cfg_err, cfg_ack, tick);
            end
        end
    endtask

    task automatic test_enable_gap();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            enable = !(n >= 3 && n <= 7);
            step();
            n_checks++;
            if ({cfg_ack, cfg_err, sq, tick} !== exp_vec()) begin
                n_fail++;
                $display("FAIL enable_gap edge %0d: got %b expected %b", n, {cfg_ack, cfg_err, sq, tick}, exp_vec());
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_sync_clr();
        logic [1:0] want;
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            sync_clr = (n == 7); cfg_we = (n == 7); cfg_ch = 2'd0; cfg_div = 8'd4;
            step();
            sync_clr = 1'b0; cfg_we = 1'b0;
            want[0] = (n == 5 || n == 11 || n == 15);
            want[1] = (n == 5 || n == 12 || n == 17);
            n_checks++;
            if (tick !== want) begin
                n_fail++;
                $display("FAIL sync_clr_tick edge %0d: got %b expected %b", n, tick, want);
            end
            n_checks++;
            if ({cfg_ack, cfg_err, sq, tick} !== exp_vec()) begin
                n_fail++;
                $display("FAIL sync_clr_model edge %0d: got %b expected %b", n, {cfg_ack, cfg_err, sq, tick}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            cfg_we = (n == 1); cfg_ch = 2'd0; cfg_div = 8'd3;
            step();
            cfg_we = 1'b0;
        end
        reset = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; sync_clr = 1'b1;
        step();
        idle_inputs();
        reset = 1'b0;
        n_checks++;
        if ({cfg_ack, cfg_err, sq, tick} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 000000", {cfg_ack, cfg_err, sq, tick});
        end
        for (int n = 1; n <= 10; n++) begin
            step();
            n_checks++;
            if (tick !== ((n % 5 == 0) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL reset_mid_period edge %0d: got %b", n, tick);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 1; n <= 24; n++) begin
            cfg_we  = 1'b1;
            cfg_ch  = CHW'(n % 3);
            cfg_div = CW'(n % 5);
            step();
            n_checks++;
            if ({cfg_ack, cfg_err, sq, tick} !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back edge %0d: got %b expected %b", n, {cfg_ack, cfg_err, sq, tick}, exp_vec());
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(199) == 0);
            enable   = ($urandom_range(9) < 8);
            sync_clr = ($urandom_range(39) == 0);
            cfg_we   = ($urandom_range(9) == 0);
            cfg_ch   = CHW'($urandom_range(3));
            cfg_div  = CW'($urandom_range(9));
            step();
            n_checks++;
            if ({cfg_ack, cfg_err, sq, tick} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b expected %b", n, {cfg_ack, cfg_err, sq, tick}, exp_vec());
            end
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_config_write();
        test_invalid_write();
        test_enable_gap();
        test_sync_clr();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
